seq_match_logger: RTL
=====================

SEQ_MATCH_LOGGER -- requirements
Module: seq_match_logger

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, event FIFO depth in entries; power of two, 2..64.
REQ-002 SHALL provide parameter TS_W, default 16, timestamp width in bits.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset: one clock; reset is synchronous and active-high.
REQ-005 SHALL provide port z  input  1  match pulse from the upstream sequence detector; each cycle z=1 is one match event.
REQ-006 SHALL provide port clr  input  1  synchronous soft clear of FIFO, counters and flags.
REQ-007 SHALL provide port ev_ready  input  1  consumer accepts the head entry.
REQ-008 SHALL provide port ev_valid  output  1  FIFO non-empty; head entry presented.
REQ-009 SHALL provide port ev_ts  output  TS_W  timestamp of head entry; 0 when ev_valid=0.
REQ-010 SHALL provide port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL provide port match_count  output  16  total matches seen, saturating.
REQ-012 SHALL provide port drop_count  output  8  matches discarded due to full FIFO, saturating.
REQ-013 SHALL provide port overflow  output  1  sticky: at least one match dropped.

Function
REQ-014 SHALL run a free-running TS_W-bit timestamp counter: 0 in the first cycle after reset deasserts, +1 every cycle, wrapping from 2^TS_W-1 to 0; clr SHALL NOT affect it.
REQ-015 SHALL, in a cycle with z=1 and no drop, push the current timestamp counter value into the FIFO; entry visible at ev_ts with ev_valid=1 in the next cycle when the FIFO was empty (1-cycle latency).
REQ-016 SHALL pop the head entry in any cycle with ev_valid=1 and ev_ready=1; ev_ready with ev_valid=0 SHALL have no effect.
REQ-017 SHALL hold ev_ts stable while ev_valid=1 and ev_ready=0.
REQ-018 SHALL deliver entries in strict push order (FIFO); read/write pointers wrap modulo DEPTH.
REQ-019 SHALL, on simultaneous push and pop with the FIFO non-empty, perform both; level unchanged.
REQ-020 SHALL, on z=1 with level=DEPTH and a pop in the same cycle, accept the push (no drop); level stays DEPTH.
REQ-021 SHALL, on z=1 with level=DEPTH and no pop, discard the event, increment drop_count (saturate at 255) and set overflow.
REQ-022 SHALL increment match_count on every z=1 cycle, dropped or not, saturating at 65535.
REQ-023 SHALL, on clr=1, empty the FIFO and zero match_count, drop_count, overflow at the next edge; z, ev_ready in that cycle SHALL be ignored.
REQ-024 SHALL give rst priority over clr, and clr priority over push/pop.
REQ-025 SHALL update level, match_count, drop_count, overflow registered, one cycle after the causing event.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, set timestamp counter 0, FIFO empty, ev_valid 0, ev_ts 0, level 0, match_count 0, drop_count 0, overflow 0.
REQ-027 SHALL, on reset mid-operation, discard all FIFO contents; no stale entry SHALL appear after reset deasserts.
REQ-028 SHALL ignore z, clr and ev_ready while rst=1.

Verification
REQ-029 Single event: reset, ev_ready=0, z=1 at timestamp 5 -> next cycle ev_valid=1, ev_ts=5, level=1, match_count=1.
REQ-030 Order/backpressure: z at ts 3,4,10, ev_ready=0 then 1 -> ev_ts reads 3,4,10 in order, held while ev_ready=0, ev_valid=0 after third pop.
REQ-031 Full: DEPTH=8, ev_ready=0, 10 z pulses -> level=8, drop_count=2, overflow=1, match_count=10; 9th pulse with simultaneous pop -> no drop.
REQ-032 Wrap: TS_W=4, z at cycles 15 and 16 after reset -> ev_ts 15 then 0; 20 push/pop cycles exercise pointer wrap with correct order.
REQ-033 Clear: 3 entries queued, clr=1 with z=1 same cycle -> next cycle level=0, ev_valid=0, counts 0, timestamp counter unaffected.
REQ-034 Reset mid-stream: 4 entries queued, rst pulse -> all outputs 0, next z yields ts relative to reset release.

Source files
------------

// File: rtl/seq_match_logger.sv
// Match-event logger: timestamps each z pulse into a FIFO drained through a
// valid/ready port, and keeps saturating match and drop statistics.
module seq_match_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     z,
  input  logic                     clr,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [TS_W-1:0]          ev_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              match_count,
  output logic [7:0]               drop_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // Handshake: the head entry is transferred in every cycle where
  // ev_valid && ev_ready; ev_valid never depends on ev_ready, and ev_ts
  // holds the head entry unchanged until it is transferred.
  assign ev_valid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign pop      = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = z && (!full || pop);
  assign drop     = z && full && !pop;
  assign ev_ts    = ev_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst && !clr && push) begin
      mem[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts          <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      match_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (clr) begin
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        level       <= '0;
        match_count <= '0;
        drop_count  <= '0;
        overflow    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (z && (match_count != 16'hFFFF)) match_count <= match_count + 1'b1;
        if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 1'b1;
        if (drop) overflow <= 1'b1;
      end
    end
  end
endmodule
